// File: rtl/reg_file_sb.sv
// Multi-write register file with per-register pending (scoreboard) bits.
// Two combinational read ports, ALU and load write ports, optional bypass and hardwired-zero r0.
module reg_file_sb #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      read0_addr,
  input  logic [ADDR_W-1:0]      read1_addr,
  output logic [DATA_W-1:0]      read0_val_o,
  output logic [DATA_W-1:0]      read1_val_o,
  output logic                   read0_busy_o,
  output logic                   read1_busy_o,
  input  logic                   wen,
  input  logic [ADDR_W-1:0]      write_addr,
  input  logic [DATA_W-1:0]      write_data,
  input  logic                   wen1,
  input  logic [ADDR_W-1:0]      write1_addr,
  input  logic [DATA_W-1:0]      write1_data,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_addr,
  output logic [(1<<ADDR_W)-1:0] pend_vec_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  we0_dec;
  logic [DEPTH-1:0]  we1_dec;
  logic [DEPTH-1:0]  set_dec;

  // One-hot decode of each port; r0 lanes are masked off when it is hardwired to zero.
  always_comb begin
    we0_dec = '0;
    we1_dec = '0;
    set_dec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      we0_dec[i] = wen      && (write_addr  == ADDR_W'(i));
      we1_dec[i] = wen1     && (write1_addr == ADDR_W'(i));
      set_dec[i] = pend_set && (pend_addr   == ADDR_W'(i));
    end
    if (ZERO_R0 != 0) begin
      we0_dec[0] = 1'b0;
      we1_dec[0] = 1'b0;
      set_dec[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (we1_dec[i]) begin
          rf[i] <= write1_data;
        end else if (we0_dec[i]) begin
          rf[i] <= write_data;
        end
      end
      // A new load issue outranks the writeback retiring the previous one.
      pend <= set_dec | (pend & ~(we0_dec | we1_dec));
    end
  end

  assign pend_vec_o = pend;

  logic [ADDR_W-1:0] raddr [2];
  assign raddr[0] = read0_addr;
  assign raddr[1] = read1_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] val;
    logic              busy;
    logic              hit0;
    logic              hit1;

    assign hit0 = (BYPASS != 0) && wen  && (write_addr  == raddr[p]);
    assign hit1 = (BYPASS != 0) && wen1 && (write1_addr == raddr[p]);

    always_comb begin
      val  = rf[raddr[p]];
      busy = pend[raddr[p]];
      if (!rst_n) begin
        val  = '0;
        busy = 1'b0;
      end else if ((ZERO_R0 != 0) && (raddr[p] == '0)) begin
        val  = '0;
        busy = 1'b0;
      end else if (hit1) begin
        val  = write1_data;
        busy = 1'b0;
      end else if (hit0) begin
        val  = write_data;
        busy = 1'b0;
      end
    end
  end

  assign read0_val_o  = g_rd[0].val;
  assign read0_busy_o = g_rd[0].busy;
  assign read1_val_o  = g_rd[1].val;
  assign read1_busy_o = g_rd[1].busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: three configurations share one stimulus stream
// and are checked against an array-based reference model.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  r0a, r1a, wa, w1a, pa;
  logic        wen, wen1, pend_set;
  logic [15:0] wd, w1d;

  logic [7:0]  a_r0v, a_r1v, b_r0v, b_r1v;
  logic        a_r0b, a_r1b, b_r0b, b_r1b;
  logic [15:0] a_pv, b_pv;
  logic [15:0] c_r0v, c_r1v;
  logic        c_r0b, c_r1b;
  logic [7:0]  c_pv;

  int checks = 0;
  int errors = 0;

  // Reference state: 8-bit/16-entry configs share storage; 16-bit/8-entry config has r0 hardwired.
  logic [7:0]  m8  [16];
  logic [15:0] p8;
  logic [15:0] m16 [8];
  logic [7:0]  p16;

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .BYPASS(1), .ZERO_R0(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .read0_addr(r0a), .read1_addr(r1a),
    .read0_val_o(a_r0v), .read1_val_o(a_r1v),
    .read0_busy_o(a_r0b), .read1_busy_o(a_r1b),
    .wen(wen), .write_addr(wa), .write_data(wd[7:0]),
    .wen1(wen1), .write1_addr(w1a), .write1_data(w1d[7:0]),
    .pend_set(pend_set), .pend_addr(pa), .pend_vec_o(a_pv)
  );

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .BYPASS(0), .ZERO_R0(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read0_addr(r0a), .read1_addr(r1a),
    .read0_val_o(b_r0v), .read1_val_o(b_r1v),
    .read0_busy_o(b_r0b), .read1_busy_o(b_r1b),
    .wen(wen), .write_addr(wa), .write_data(wd[7:0]),
    .wen1(wen1), .write1_addr(w1a), .write1_data(w1d[7:0]),
    .pend_set(pend_set), .pend_addr(pa), .pend_vec_o(b_pv)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .read0_addr(r0a[2:0]), .read1_addr(r1a[2:0]),
    .read0_val_o(c_r0v), .read1_val_o(c_r1v),
    .read0_busy_o(c_r0b), .read1_busy_o(c_r1b),
    .wen(wen), .write_addr(wa[2:0]), .write_data(wd),
    .wen1(wen1), .write1_addr(w1a[2:0]), .write1_data(w1d),
    .pend_set(pend_set), .pend_addr(pa[2:0]), .pend_vec_o(c_pv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!$isunknown({wen, wen1, pend_set, wa, w1a, pa, r0a, r1a}))
        else $error("X on enable or address while out of reset");
    end
  end

  // Model: later assignment wins, so the load port is applied after the ALU port
  // and pend_set after the writeback clears.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m8[i] = '0;
      for (int i = 0; i < 8; i++)  m16[i] = '0;
      p8  = '0;
      p16 = '0;
    end else begin
      if (wen)  m8[wa]  = wd[7:0];
      if (wen1) m8[w1a] = w1d[7:0];
      if (wen)  p8[wa]  = 1'b0;
      if (wen1) p8[w1a] = 1'b0;
      if (pend_set) p8[pa] = 1'b1;
      if (wen  && wa[2:0]  != 3'd0) m16[wa[2:0]]  = wd;
      if (wen1 && w1a[2:0] != 3'd0) m16[w1a[2:0]] = w1d;
      if (wen  && wa[2:0]  != 3'd0) p16[wa[2:0]]  = 1'b0;
      if (wen1 && w1a[2:0] != 3'd0) p16[w1a[2:0]] = 1'b0;
      if (pend_set && pa[2:0] != 3'd0) p16[pa[2:0]] = 1'b1;
    end
  end

  // Expected {busy, value} for the 8-bit configs.
  function automatic logic [8:0] ref8(input bit byp, input logic [3:0] a);
    if (!rst_n) return '0;
    if (byp && wen1 && w1a == a) return {1'b0, w1d[7:0]};
    if (byp && wen && wa == a)   return {1'b0, wd[7:0]};
    return {p8[a], m8[a]};
  endfunction

  // Expected {busy, value} for the hardwired-zero 16-bit config.
  function automatic logic [16:0] ref16(input logic [2:0] a);
    if (!rst_n) return '0;
    if (a == 3'd0) return '0;
    if (wen1 && w1a[2:0] == a) return {1'b0, w1d};
    if (wen && wa[2:0] == a)   return {1'b0, wd};
    return {p16[a], m16[a]};
  endfunction

  task automatic idle();
    wen = 1'b0; wen1 = 1'b0; pend_set = 1'b0;
    wa = '0; w1a = '0; pa = '0; wd = '0; w1d = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    r0a = 4'd5; r1a = 4'd5;
    wen = 1'b1; wa = 4'd5; wd = 16'hFFFF; pend_set = 1'b1; pa = 4'd5;
    step();
    step();
    #1;
    checks++; if (a_r0v !== 8'h00) begin errors++; $display("FAIL rst_val_a: got %h exp 00", a_r0v); end
    checks++; if (a_r0b !== 1'b0) begin errors++; $display("FAIL rst_busy_a: got %b exp 0", a_r0b); end
    checks++; if (a_pv !== 16'h0000) begin errors++; $display("FAIL rst_pvec_a: got %h exp 0000", a_pv); end
    checks++; if (c_pv !== 8'h00) begin errors++; $display("FAIL rst_pvec_c: got %h exp 00", c_pv); end
    checks++; if (c_r1v !== 16'h0000) begin errors++; $display("FAIL rst_val_c: got %h exp 0000", c_r1v); end
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    wen = 1'b1; wa = 4'd3; wd = 16'h00A5;
    step();
    idle(); pend_set = 1'b1; pa = 4'd5;
    step();
    idle(); r0a = 4'd3; r1a = 4'd5;
    #1;
    checks++; if (a_r0v !== 8'hA5) begin errors++; $display("FAIL rmid_pre_val: got %h exp a5", a_r0v); end
    checks++; if (a_r1b !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy: got %b exp 1", a_r1b); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a_r0v !== 8'h00) begin errors++; $display("FAIL rmid_val: got %h exp 00", a_r0v); end
    checks++; if (a_pv !== 16'h0000) begin errors++; $display("FAIL rmid_pvec_a: got %h exp 0000", a_pv); end
    checks++; if (b_pv !== 16'h0000) begin errors++; $display("FAIL rmid_pvec_b: got %h exp 0000", b_pv); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_collision();
    wen = 1'b1;  wa  = 4'd4; wd  = 16'h0011;
    wen1 = 1'b1; w1a = 4'd4; w1d = 16'h0022;
    r0a = 4'd4;
    #1;
    checks++; if (a_r0v !== 8'h22) begin errors++; $display("FAIL coll_byp_a: got %h exp 22", a_r0v); end
    checks++; if (c_r0v !== 16'h0022) begin errors++; $display("FAIL coll_byp_c: got %h exp 0022", c_r0v); end
    checks++; if (b_r0v !== 8'h00) begin errors++; $display("FAIL coll_nobyp_b: got %h exp 00", b_r0v); end
    step();
    idle(); r0a = 4'd4;
    #1;
    checks++; if (b_r0v !== 8'h22) begin errors++; $display("FAIL coll_stored_b: got %h exp 22", b_r0v); end
    checks++; if (c_r0v !== 16'h0022) begin errors++; $display("FAIL coll_stored_c: got %h exp 0022", c_r0v); end
  endtask

  task automatic test_bypass();
    wen = 1'b1; wa = 4'd2; wd = 16'h0010;
    step();
    wen = 1'b1; wa = 4'd2; wd = 16'h007E; r0a = 4'd2;
    #1;
    checks++; if (b_r0v !== 8'h10) begin errors++; $display("FAIL byp_off_same: got %h exp 10", b_r0v); end
    checks++; if (a_r0v !== 8'h7E) begin errors++; $display("FAIL byp_on_same: got %h exp 7e", a_r0v); end
    step();
    idle(); r0a = 4'd2;
    #1;
    checks++; if (b_r0v !== 8'h7E) begin errors++; $display("FAIL byp_off_next: got %h exp 7e", b_r0v); end
    checks++; if (a_r0v !== 8'h7E) begin errors++; $display("FAIL byp_on_next: got %h exp 7e", a_r0v); end
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pa = 4'd6;
    step();
    idle(); r1a = 4'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (a_r1b !== 1'b1) begin errors++; $display("FAIL sb_busy_a: got %b exp 1", a_r1b); end
      checks++; if (b_r1b !== 1'b1) begin errors++; $display("FAIL sb_busy_b: got %b exp 1", b_r1b); end
      step();
    end
    wen1 = 1'b1; w1a = 4'd6; w1d = 16'h003C;
    #1;
    checks++; if (a_r1b !== 1'b0) begin errors++; $display("FAIL sb_wb_busy_a: got %b exp 0", a_r1b); end
    checks++; if (a_r1v !== 8'h3C) begin errors++; $display("FAIL sb_wb_val_a: got %h exp 3c", a_r1v); end
    checks++; if (b_r1b !== 1'b1) begin errors++; $display("FAIL sb_wb_busy_b: got %b exp 1", b_r1b); end
    checks++; if (a_pv[6] !== 1'b1) begin errors++; $display("FAIL sb_wb_pvec: got %b exp 1", a_pv[6]); end
    step();
    idle(); r1a = 4'd6;
    #1;
    checks++; if (a_pv[6] !== 1'b0) begin errors++; $display("FAIL sb_clr_pvec: got %b exp 0", a_pv[6]); end
    checks++; if (b_r1b !== 1'b0) begin errors++; $display("FAIL sb_clr_busy_b: got %b exp 0", b_r1b); end
    checks++; if (b_r1v !== 8'h3C) begin errors++; $display("FAIL sb_clr_val_b: got %h exp 3c", b_r1v); end
  endtask

  task automatic test_race();
    pend_set = 1'b1; pa = 4'd6;
    wen1 = 1'b1; w1a = 4'd6; w1d = 16'h005A;
    step();
    idle(); r1a = 4'd6;
    #1;
    checks++; if (a_pv[6] !== 1'b1) begin errors++; $display("FAIL race_pvec: got %b exp 1", a_pv[6]); end
    checks++; if (b_r1v !== 8'h5A) begin errors++; $display("FAIL race_val: got %h exp 5a", b_r1v); end
    checks++; if (b_r1b !== 1'b1) begin errors++; $display("FAIL race_busy: got %b exp 1", b_r1b); end
  endtask

  task automatic test_zero_r0();
    wen = 1'b1; wa = 4'd0; wd = 16'hBEEF;
    pend_set = 1'b1; pa = 4'd0; r0a = 4'd0;
    #1;
    checks++; if (c_r0v !== 16'h0000) begin errors++; $display("FAIL z_byp_val: got %h exp 0000", c_r0v); end
    step();
    idle(); wen = 1'b1; wa = 4'd7; wd = 16'hBEEF;
    step();
    idle(); r0a = 4'd0; r1a = 4'd7;
    #1;
    checks++; if (c_r0v !== 16'h0000) begin errors++; $display("FAIL z_r0_val: got %h exp 0000", c_r0v); end
    checks++; if (c_r0b !== 1'b0) begin errors++; $display("FAIL z_r0_busy: got %b exp 0", c_r0b); end
    checks++; if (c_pv[0] !== 1'b0) begin errors++; $display("FAIL z_r0_pvec: got %b exp 0", c_pv[0]); end
    checks++; if (c_r1v !== 16'hBEEF) begin errors++; $display("FAIL z_r7_val: got %h exp beef", c_r1v); end
    checks++; if (a_r0v !== 8'hEF) begin errors++; $display("FAIL z_nz_r0_val: got %h exp ef", a_r0v); end
    checks++; if (a_r0b !== 1'b1) begin errors++; $display("FAIL z_nz_r0_busy: got %b exp 1", a_r0b); end
  endtask

  task automatic test_random();
    logic [8:0]  e8;
    logic [16:0] e16;
    for (int n = 0; n < 300; n++) begin
      wen  = ($urandom_range(0, 2) != 0);
      wen1 = ($urandom_range(0, 2) == 0);
      pend_set = ($urandom_range(0, 3) == 0);
      wa  = 4'($urandom_range(0, 15));
      w1a = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      pa  = ($urandom_range(0, 3) == 0) ? w1a : 4'($urandom_range(0, 15));
      r0a = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      r1a = ($urandom_range(0, 2) == 0) ? w1a : 4'($urandom_range(0, 15));
      wd  = 16'($urandom);
      w1d = 16'($urandom);
      #1;
      e8 = ref8(1'b1, r0a);
      checks++; if ({a_r0b, a_r0v} !== e8) begin errors++; $display("FAIL rnd_a_rd0: got %h exp %h", {a_r0b, a_r0v}, e8); end
      e8 = ref8(1'b1, r1a);
      checks++; if ({a_r1b, a_r1v} !== e8) begin errors++; $display("FAIL rnd_a_rd1: got %h exp %h", {a_r1b, a_r1v}, e8); end
      e8 = ref8(1'b0, r0a);
      checks++; if ({b_r0b, b_r0v} !== e8) begin errors++; $display("FAIL rnd_b_rd0: got %h exp %h", {b_r0b, b_r0v}, e8); end
      e8 = ref8(1'b0, r1a);
      checks++; if ({b_r1b, b_r1v} !== e8) begin errors++; $display("FAIL rnd_b_rd1: got %h exp %h", {b_r1b, b_r1v}, e8); end
      e16 = ref16(r0a[2:0]);
      checks++; if ({c_r0b, c_r0v} !== e16) begin errors++; $display("FAIL rnd_c_rd0: got %h exp %h", {c_r0b, c_r0v}, e16); end
      e16 = ref16(r1a[2:0]);
      checks++; if ({c_r1b, c_r1v} !== e16) begin errors++; $display("FAIL rnd_c_rd1: got %h exp %h", {c_r1b, c_r1v}, e16); end
      checks++; if (a_pv !== p8) begin errors++; $display("FAIL rnd_a_pvec: got %h exp %h", a_pv, p8); end
      checks++; if (b_pv !== p8) begin errors++; $display("FAIL rnd_b_pvec: got %h exp %h", b_pv, p8); end
      checks++; if (c_pv !== p16) begin errors++; $display("FAIL rnd_c_pvec: got %h exp %h", c_pv, p16); end
      step();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    r0a = '0; r1a = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_race();
    test_zero_r0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
